// File: rtl/wb_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_req_pkg
// Brief    : Shared request type, sequencer states and defaults for wb_req_queue.
// Revision : 1.0 - initial release
// ============================================================================
package wb_req_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic [2:0]  naccess;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } wbq_state_e;

    localparam logic [31:0] c_err_data_default = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/wb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_req_fifo
// Brief    : Synchronous request FIFO with wrap-bit pointers and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module wb_req_fifo
    import wb_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic                   i_push,
    input  wb_req_t                i_data,
    input  logic                   i_pop,
    output wb_req_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t       r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/wb_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_req_queue
// Brief    : Buffers core requests and issues them one at a time to wb_master,
//            returning data/ack (or a timeout error) on a ready/valid port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_req_queue
    import wb_req_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = c_err_data_default
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic [31:0]            req_data_i,
    input  logic [3:0]             req_we_i,
    input  logic [2:0]             req_naccess_i,
    output logic                   m_valid_o,
    output logic [31:0]            m_addr_o,
    output logic [31:0]            m_data_o,
    output logic [3:0]             m_we_o,
    output logic [2:0]             m_naccess_o,
    input  logic                   m_valid_i,
    input  logic [31:0]            m_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_write_o,
    output logic                   rsp_err_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int               CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_tcnt_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] c_tcnt_max  = '1;

    wbq_state_e       r_state;
    wbq_state_e       w_next_state;
    wb_req_t          w_fifo_in;
    wb_req_t          w_fifo_head;
    wb_req_t          r_issue;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_complete;
    logic             w_expire;
    logic             w_issue_is_write;
    logic             r_head_seen;
    logic [CNT_W-1:0] r_tcnt;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_write;
    logic             r_rsp_err;

    assign w_fifo_in        = '{addr: req_addr_i, data: req_data_i,
                                we: req_we_i, naccess: req_naccess_i};
    assign req_ready_o      = !w_fifo_full;
    assign w_issue_is_write = (r_issue.we != 4'd0);

    wb_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn_i  (rstn_i),
        .i_push  (req_valid_i),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (level_o)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_complete   = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            // The sequencer acts on the registered non-empty view, so a freshly
            // written head is issued one cycle after it becomes visible.
            IDLE: begin
                if (r_head_seen && !w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (m_valid_i) begin
                    w_complete   = 1'b1;
                    w_next_state = RESP;
                end else if ((TIMEOUT != 0) && (r_tcnt == c_tcnt_last)) begin
                    w_expire     = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_head_seen <= 1'b0;
            r_issue     <= '0;
            r_tcnt      <= '0;
            r_rsp_data  <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_head_seen <= !w_fifo_empty;
            if (w_pop) begin
                r_issue <= w_fifo_head;
                r_tcnt  <= '0;
            end else if ((r_state == ISSUE) && (r_tcnt != c_tcnt_max)) begin
                r_tcnt  <= r_tcnt + CNT_W'(1);
            end
            if (w_complete) begin
                r_rsp_data  <= w_issue_is_write ? 32'd0 : m_data_i;
                r_rsp_write <= w_issue_is_write;
                r_rsp_err   <= 1'b0;
            end else if (w_expire) begin
                r_rsp_data  <= ERR_DATA;
                r_rsp_write <= w_issue_is_write;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign m_valid_o   = (r_state == ISSUE);
    assign m_addr_o    = r_issue.addr;
    assign m_data_o    = r_issue.data;
    assign m_we_o      = r_issue.we;
    assign m_naccess_o = r_issue.naccess;

    assign rsp_valid_o = (r_state == RESP);
    assign rsp_data_o  = r_rsp_data;
    assign rsp_write_o = r_rsp_write;
    assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_req_queue
// Brief    : Scenario bench for wb_req_queue with a latency-programmable bus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_req_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        write;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_we_i = '0;
    logic [2:0]  req_naccess_i = '0;
    logic        m_valid_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_we_o;
    logic [2:0]  m_naccess_o;
    logic        m_valid_i;
    logic [31:0] m_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_write_o;
    logic        rsp_err_o;
    logic [2:0]  level_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    // Bus model: completes after bus_lat cycles of m_valid_o (0 = never).
    int          bus_lat = 0;
    int          bus_cnt = 0;
    logic        bus_hit = 1'b0;
    logic        inject = 1'b0;
    logic        bus_addr_mode = 1'b0;
    logic [31:0] bus_rdata = '0;

    assign m_valid_i = bus_hit | inject;
    assign m_data_i  = bus_addr_mode ? ~m_addr_o : bus_rdata;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_valid_o) bus_cnt = bus_cnt + 1;
        else           bus_cnt = 0;
        bus_hit = (bus_lat != 0) && (bus_cnt == bus_lat);
    end

    wb_req_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rstn_i        (rstn_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .req_we_i      (req_we_i),
        .req_naccess_i (req_naccess_i),
        .m_valid_o     (m_valid_o),
        .m_addr_o      (m_addr_o),
        .m_data_o      (m_data_o),
        .m_we_o        (m_we_o),
        .m_naccess_o   (m_naccess_o),
        .m_valid_i     (m_valid_i),
        .m_data_i      (m_data_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_write_o   (rsp_write_o),
        .rsp_err_o     (rsp_err_o),
        .level_o       (level_o)
    );

    function automatic exp_t mk_exp(input logic [31:0] d, input logic w, input logic e);
        exp_t x;
        x.data  = d;
        x.write = w;
        x.err   = e;
        return x;
    endfunction

    // Called and returning on a falling edge; drops valid once accepted.
    task automatic push_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] we, input logic [2:0] na, output bit ok);
        ok            = 1'b0;
        req_valid_i   = 1'b1;
        req_addr_i    = a;
        req_data_i    = d;
        req_we_i      = we;
        req_naccess_i = na;
        for (int i = 0; i < 200; i++) begin
            if (req_ready_o) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_mvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_valid_o, rsp_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_during: m_valid=%b rsp_valid=%b, expected 0 0", m_valid_o, rsp_valid_o);
        end
        rstn_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready_o !== 1'b1 || level_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: ready=%b level=%0d, expected 1 0", req_ready_o, level_o);
        end
        n_cmp++;
        if ({rsp_data_o, rsp_write_o, rsp_err_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: data=%h write=%b err=%b, expected all 0", rsp_data_o, rsp_write_o, rsp_err_o);
        end
        n_cmp++;
        if ({m_valid_o, m_addr_o, m_data_o, m_we_o, m_naccess_o} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_master: valid=%b addr=%h data=%h we=%b na=%0d, expected all 0",
                     m_valid_o, m_addr_o, m_data_o, m_we_o, m_naccess_o);
        end
    endtask

    task automatic test_single_read();
        bit   ok;
        int   hi;
        exp_t e;
        rsp_ready_i   = 1'b1;
        bus_addr_mode = 1'b0;
        bus_rdata     = 32'h1234_5678;
        bus_lat       = 3;
        sb.push_back(mk_exp(32'h1234_5678, 1'b0, 1'b0));
        push_req(32'h10, 32'h0, 4'h0, 3'd1, ok);
        n_cmp++;
        if (!ok || m_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_accept: accepted=%b m_valid=%b, expected 1 0", ok, m_valid_o);
        end
        @(negedge clk);
        n_cmp++;
        if (m_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_latency_early: m_valid=%b one cycle after accept, expected 0", m_valid_o);
        end
        @(negedge clk);
        n_cmp++;
        if (m_valid_o !== 1'b1 || m_addr_o !== 32'h10 || m_we_o !== 4'h0 || m_naccess_o !== 3'd1) begin
            n_fail++;
            $display("FAIL read_issue: valid=%b addr=%h we=%b na=%0d, expected 1 00000010 0000 1",
                     m_valid_o, m_addr_o, m_we_o, m_naccess_o);
        end
        hi = 0;
        while (m_valid_o === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi != 3) begin
            n_fail++;
            $display("FAIL read_mvalid_len: m_valid high %0d cycles, expected 3", hi);
        end
        n_cmp++;
        if (rsp_valid_o !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL read_rsp_valid: rsp_valid=%b after completion, expected 1", rsp_valid_o);
        end else begin
            e = sb.pop_front();
            if ({rsp_data_o, rsp_write_o, rsp_err_o} !== e) begin
                n_fail++;
                $display("FAIL read_rsp: got data=%h write=%b err=%b, expected data=%h write=%b err=%b",
                         rsp_data_o, rsp_write_o, rsp_err_o, e.data, e.write, e.err);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp_consumed: rsp_valid=%b, expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_write();
        bit   ok;
        bit   stable;
        int   hi;
        exp_t e;
        rsp_ready_i   = 1'b1;
        bus_addr_mode = 1'b0;
        bus_rdata     = 32'h1234_5678;
        bus_lat       = 4;
        sb.push_back(mk_exp(32'h0, 1'b1, 1'b0));
        push_req(32'h20, 32'hAABB_CCDD, 4'b0011, 3'd2, ok);
        wait_mvalid(ok);
        stable = 1'b1;
        hi     = 0;
        while (m_valid_o === 1'b1 && hi < 50) begin
            if (m_we_o !== 4'b0011 || m_data_o !== 32'hAABB_CCDD ||
                m_addr_o !== 32'h20 || m_naccess_o !== 3'd2) stable = 1'b0;
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (!ok || !stable || hi != 4) begin
            n_fail++;
            $display("FAIL write_issue: seen=%b stable=%b cycles=%0d, expected 1 1 4", ok, stable, hi);
        end
        wait_rsp(ok);
        n_cmp++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL write_rsp_valid: rsp_valid=%b, expected 1", rsp_valid_o);
        end else begin
            e = sb.pop_front();
            if ({rsp_data_o, rsp_write_o, rsp_err_o} !== e) begin
                n_fail++;
                $display("FAIL write_rsp: got data=%h write=%b err=%b, expected data=%h write=%b err=%b",
                         rsp_data_o, rsp_write_o, rsp_err_o, e.data, e.write, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fill_overflow();
        bit          ok;
        bit          ok6;
        logic [31:0] a;
        logic [3:0]  we;
        exp_t        e;
        rsp_ready_i   = 1'b0;
        bus_addr_mode = 1'b1;
        bus_lat       = 2;
        for (int i = 0; i < 5; i++) begin
            a  = 32'h100 + 32'(i * 4);
            we = (i == 2) ? 4'hF : 4'h0;
            sb.push_back((we != 4'h0) ? mk_exp(32'h0, 1'b1, 1'b0) : mk_exp(~a, 1'b0, 1'b0));
            push_req(a, 32'h5000 + 32'(i), we, 3'(i), ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL fill_accept: request %0d not accepted", i);
            end
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (level_o !== 3'd4 || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: level=%0d ready=%b, expected 4 0", level_o, req_ready_o);
        end
        n_cmp++;
        if (rsp_valid_o !== 1'b1 || m_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_held: rsp_valid=%b m_valid=%b, expected 1 0", rsp_valid_o, m_valid_o);
        end
        sb.push_back(mk_exp(~32'h114, 1'b0, 1'b0));
        fork
            begin
                push_req(32'h114, 32'h0, 4'h0, 3'd5, ok6);
            end
            begin
                bit okr;
                exp_t er;
                rsp_ready_i = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    wait_rsp(okr);
                    n_cmp++;
                    if (!okr || sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL fill_rsp_valid: response %0d missing", k);
                    end else begin
                        er = sb.pop_front();
                        if ({rsp_data_o, rsp_write_o, rsp_err_o} !== er) begin
                            n_fail++;
                            $display("FAIL fill_rsp: #%0d got data=%h write=%b err=%b, expected data=%h write=%b err=%b",
                                     k, rsp_data_o, rsp_write_o, rsp_err_o, er.data, er.write, er.err);
                        end
                    end
                    @(negedge clk);
                end
            end
        join
        n_cmp++;
        if (!ok6 || level_o !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_drain: sixth accepted=%b level=%0d, expected 1 0", ok6, level_o);
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        int   cyc;
        int   nrsp;
        int   rises[$];
        logic prev;
        exp_t e;
        rsp_ready_i   = 1'b1;
        bus_addr_mode = 1'b1;
        bus_lat       = 2;
        for (int i = 0; i < 3; i++) sb.push_back(mk_exp(~(32'h200 + 32'(i * 4)), 1'b0, 1'b0));
        fork
            begin
                for (int i = 0; i < 3; i++) push_req(32'h200 + 32'(i * 4), 32'h0, 4'h0, 3'd0, ok);
            end
            begin
                cyc  = 0;
                nrsp = 0;
                prev = 1'b0;
                while (nrsp < 3 && cyc < 100) begin
                    if (m_valid_o && !prev) rises.push_back(cyc);
                    prev = m_valid_o;
                    if (rsp_valid_o) begin
                        n_cmp++;
                        e = (sb.size() != 0) ? sb.pop_front() : mk_exp(32'hx, 1'bx, 1'bx);
                        if ({rsp_data_o, rsp_write_o, rsp_err_o} !== e) begin
                            n_fail++;
                            $display("FAIL b2b_rsp: #%0d got data=%h write=%b err=%b, expected data=%h write=%b err=%b",
                                     nrsp, rsp_data_o, rsp_write_o, rsp_err_o, e.data, e.write, e.err);
                        end
                        nrsp++;
                    end
                    cyc++;
                    @(negedge clk);
                end
            end
        join
        n_cmp++;
        if (rises.size() != 3 || (rises[1] - rises[0]) != 4 || (rises[2] - rises[1]) != 4) begin
            n_fail++;
            $display("FAIL b2b_rate: %0d issues, spacing %0d/%0d, expected 3 issues spaced 4/4",
                     rises.size(), (rises.size() > 1) ? rises[1] - rises[0] : -1,
                     (rises.size() > 2) ? rises[2] - rises[1] : -1);
        end
    endtask

    task automatic test_timeout();
        bit   ok;
        bit   quiet;
        int   hi;
        exp_t e;
        rsp_ready_i   = 1'b0;
        bus_addr_mode = 1'b0;
        bus_lat       = 0;
        sb.push_back(mk_exp(32'hDEAD_BEEF, 1'b0, 1'b1));
        push_req(32'h40, 32'h0, 4'h0, 3'd0, ok);
        wait_mvalid(ok);
        hi = 0;
        while (m_valid_o === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (!ok || hi != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: m_valid high %0d cycles, expected %0d", hi, TIMEOUT);
        end
        n_cmp++;
        if (rsp_valid_o !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL timeout_rsp_valid: rsp_valid=%b, expected 1", rsp_valid_o);
        end else begin
            e = sb.pop_front();
            if ({rsp_data_o, rsp_write_o, rsp_err_o} !== e) begin
                n_fail++;
                $display("FAIL timeout_rsp: got data=%h write=%b err=%b, expected data=%h write=%b err=%b",
                         rsp_data_o, rsp_write_o, rsp_err_o, e.data, e.write, e.err);
            end
        end
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_data_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL timeout_late_in_resp: valid=%b err=%b data=%h, expected 1 1 deadbeef",
                     rsp_valid_o, rsp_err_o, rsp_data_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        quiet  = 1'b1;
        repeat (4) begin
            if (rsp_valid_o !== 1'b0 || m_valid_o !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL timeout_late_in_idle: stray completion produced activity, expected none");
        end
    endtask

    task automatic test_expiry_race();
        bit   ok;
        int   hi;
        exp_t e;
        rsp_ready_i   = 1'b0;
        bus_addr_mode = 1'b0;
        bus_rdata     = 32'hCAFE_F00D;
        bus_lat       = TIMEOUT;
        sb.push_back(mk_exp(32'hCAFE_F00D, 1'b0, 1'b0));
        push_req(32'h80, 32'h0, 4'h0, 3'd3, ok);
        wait_mvalid(ok);
        hi = 0;
        while (m_valid_o === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (!ok || hi != TIMEOUT) begin
            n_fail++;
            $display("FAIL race_len: m_valid high %0d cycles, expected %0d", hi, TIMEOUT);
        end
        wait_rsp(ok);
        n_cmp++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL race_rsp_valid: rsp_valid=%b, expected 1", rsp_valid_o);
        end else begin
            e = sb.pop_front();
            if ({rsp_data_o, rsp_write_o, rsp_err_o} !== e) begin
                n_fail++;
                $display("FAIL race_rsp: got data=%h write=%b err=%b, expected data=%h write=%b err=%b",
                         rsp_data_o, rsp_write_o, rsp_err_o, e.data, e.write, e.err);
            end
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit quiet;
        rsp_ready_i = 1'b1;
        bus_lat     = 0;
        for (int i = 0; i < 3; i++) push_req(32'h300 + 32'(i * 4), 32'h0, 4'h0, 3'd0, ok);
        n_cmp++;
        if (m_valid_o !== 1'b1 || level_o !== 3'd2) begin
            n_fail++;
            $display("FAIL rstmid_setup: m_valid=%b level=%0d, expected 1 2", m_valid_o, level_o);
        end
        #2 rstn_i = 1'b0;
        #1;
        n_cmp++;
        if (m_valid_o !== 1'b0 || rsp_valid_o !== 1'b0 || level_o !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: m_valid=%b rsp_valid=%b level=%0d, expected 0 0 0",
                     m_valid_o, rsp_valid_o, level_o);
        end
        @(negedge clk);
        rstn_i = 1'b1;
        quiet  = 1'b1;
        repeat (20) begin
            if (m_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!quiet || level_o !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_after: activity=%b level=%0d after release, expected 0 0", !quiet, level_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_read();
        test_write();
        test_fill_overflow();
        test_back_to_back();
        test_timeout();
        test_expiry_race();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d expected responses never seen, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
